// File: rtl/led_dimmer_pkg.sv
// ---------------------------------------------------------------------------
// led_dimmer_pkg
// Shared definitions for the LED dimmer path.
//   - fade_state_e : state encoding of the brightness sequencer
//   - DEF_DUTY_W   : default width of duty/target/step words
//   - DEF_HOLD_W   : default width of the endpoint hold counter (in ticks)
// ---------------------------------------------------------------------------
package led_dimmer_pkg;

  localparam int DEF_DUTY_W = 8;
  localparam int DEF_HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } fade_state_e;

endpackage : led_dimmer_pkg

// File: rtl/fade_step_sat.sv
// ---------------------------------------------------------------------------
// fade_step_sat
// Combinational saturating step: moves cur one step of size stp toward goal
// and never overshoots goal or wraps the word.
// Ports:
//   cur       in  W  current duty
//   goal      in  W  destination duty
//   stp       in  W  step size
//   next_duty out W  cur stepped toward goal, clamped to goal
// ---------------------------------------------------------------------------
module fade_step_sat #(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] goal,
  input  logic [W-1:0] stp,
  output logic [W-1:0] next_duty
);

  // One extra bit so the carry/borrow is visible instead of wrapping.
  logic [W:0] w_up;
  logic [W:0] w_dn;

  assign w_up = {1'b0, cur} + {1'b0, stp};
  assign w_dn = {1'b0, cur} - {1'b0, stp};

  always_comb begin
    next_duty = cur;
    if (cur < goal) begin
      next_duty = (w_up >= {1'b0, goal}) ? goal : w_up[W-1:0];
    end else if (cur > goal) begin
      // Borrow bit set means the subtraction went below zero.
      next_duty = (w_dn[W] || (w_dn[W-1:0] <= goal)) ? goal : w_dn[W-1:0];
    end
  end

endmodule : fade_step_sat

// File: rtl/led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl
// Brightness sequencer: ramps the PWM duty word toward a programmed target,
// one step per divider tick. Breathe mode oscillates between the start level
// and the target with an optional dwell at each endpoint.
// Ports:
//   clk        in  1       system clock, rising edge
//   rst        in  1       asynchronous active-high reset
//   tick       in  1       one-cycle step strobe from the divider
//   start      in  1       begin a fade (sampled only in IDLE)
//   stop       in  1       abort; duty freezes (beats start and tick)
//   breathe    in  1       continuous oscillation, latched at start
//   target     in  DUTY_W  destination duty, latched at start
//   step       in  DUTY_W  increment per tick (0 means 1), latched at start
//   hold_ticks in  HOLD_W  endpoint dwell in ticks, latched at start
//   duty       out DUTY_W  registered duty word
//   busy       out 1       registered, high in RAMP or HOLD
//   done       out 1       registered one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module led_fade_ctrl
  import led_dimmer_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              breathe,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] step,
  input  logic [HOLD_W-1:0] hold_ticks,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  fade_state_e       r_state;
  logic [DUTY_W-1:0] r_duty;
  logic              r_busy;
  logic              r_done;
  logic [DUTY_W-1:0] r_hi_lvl;
  logic [DUTY_W-1:0] r_lo_lvl;
  logic [DUTY_W-1:0] r_goal;
  logic [DUTY_W-1:0] r_stp;
  logic [HOLD_W-1:0] r_hold;
  logic              r_brth;
  logic [HOLD_W-1:0] r_hold_cnt;

  fade_state_e       w_state_next;
  logic [DUTY_W-1:0] w_duty_next;
  logic              w_done_next;
  logic [DUTY_W-1:0] w_hi_next;
  logic [DUTY_W-1:0] w_lo_next;
  logic [DUTY_W-1:0] w_goal_next;
  logic [DUTY_W-1:0] w_stp_next;
  logic [HOLD_W-1:0] w_hold_next;
  logic              w_brth_next;
  logic [HOLD_W-1:0] w_hold_cnt_next;

  logic [DUTY_W-1:0] w_stepped;
  logic [DUTY_W-1:0] w_goal_swap;
  logic              w_at_goal;

  fade_step_sat #(.W(DUTY_W)) u_step (
    .cur       (r_duty),
    .goal      (r_goal),
    .stp       (r_stp),
    .next_duty (w_stepped)
  );

  assign w_at_goal   = (r_duty == r_goal);
  // When hi==lo both branches give the same level, so duty simply stays put.
  assign w_goal_swap = (r_goal == r_hi_lvl) ? r_lo_lvl : r_hi_lvl;

  always_comb begin
    w_state_next    = r_state;
    w_duty_next     = r_duty;
    w_done_next     = 1'b0;
    w_hi_next       = r_hi_lvl;
    w_lo_next       = r_lo_lvl;
    w_goal_next     = r_goal;
    w_stp_next      = r_stp;
    w_hold_next     = r_hold;
    w_brth_next     = r_brth;
    w_hold_cnt_next = r_hold_cnt;

    if (stop) begin
      // Abort wins over everything else this cycle; duty is left frozen.
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_hi_next    = target;
            w_lo_next    = r_duty;
            w_goal_next  = target;
            w_stp_next   = (step == '0) ? DUTY_W'(1) : step;
            w_hold_next  = hold_ticks;
            w_brth_next  = breathe;
            w_state_next = ST_RAMP;
          end
        end

        ST_RAMP: begin
          // Endpoint handling takes precedence over a coincident tick.
          if (w_at_goal) begin
            if (!r_brth) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
            end else if (r_hold == '0) begin
              w_goal_next = w_goal_swap;
            end else begin
              w_hold_cnt_next = r_hold;
              w_state_next    = ST_HOLD;
            end
          end else if (tick) begin
            w_duty_next = w_stepped;
          end
        end

        ST_HOLD: begin
          if (tick) begin
            w_hold_cnt_next = r_hold_cnt - HOLD_W'(1);
            // Counter hitting zero on this tick ends the dwell.
            if (r_hold_cnt <= HOLD_W'(1)) begin
              w_hold_cnt_next = '0;
              w_goal_next     = w_goal_swap;
              w_state_next    = ST_RAMP;
            end
          end
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_duty     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi_lvl   <= '0;
      r_lo_lvl   <= '0;
      r_goal     <= '0;
      r_stp      <= '0;
      r_hold     <= '0;
      r_brth     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_duty     <= w_duty_next;
      r_busy     <= (w_state_next != ST_IDLE);
      r_done     <= w_done_next;
      r_hi_lvl   <= w_hi_next;
      r_lo_lvl   <= w_lo_next;
      r_goal     <= w_goal_next;
      r_stp      <= w_stp_next;
      r_hold     <= w_hold_next;
      r_brth     <= w_brth_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  assign duty = r_duty;
  assign busy = r_busy;
  assign done = r_done;

endmodule : led_fade_ctrl

// File: tb/tb_led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_fade_ctrl
// Directed bench for led_fade_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period after the active edge.
// ---------------------------------------------------------------------------
module tb_led_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       breathe = 1'b0;
  logic [7:0] target = '0;
  logic [7:0] step = '0;
  logic [7:0] hold_ticks = '0;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int done_base;

  led_fade_ctrl #(.DUTY_W(8), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .breathe    (breathe),
    .target     (target),
    .step       (step),
    .hold_ticks (hold_ticks),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Count cycles with done high, to catch stray pulses.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-16s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Idle 9 cycles, then one tick cycle: a tick every 10 clocks.
  task automatic pulse_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] t, input logic [7:0] s,
                          input logic b, input logic [7:0] h);
    target = t; step = s; breathe = b; hold_ticks = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // ---------------- up-ramp 0 -> 100, step 30 ----------------
    do_start(8'd100, 8'd30, 1'b0, 8'd0);
    check("up_busy0", busy, 1);
    pulse_tick(); check("up_t1", duty, 30);
    pulse_tick(); check("up_t2", duty, 60);
    pulse_tick(); check("up_t3", duty, 90);
    pulse_tick(); check("up_t4", duty, 100);
    check("up_done_early", done, 0);
    @(negedge clk);
    check("up_done", done, 1);
    check("up_busy_fall", busy, 0);
    @(negedge clk);
    check("up_done_1cyc", done, 0);

    // ---------------- down-ramp 100 -> 97, step 0 (=1) ----------------
    do_start(8'd97, 8'd0, 1'b0, 8'd0);
    pulse_tick(); check("dn_t1", duty, 99);
    pulse_tick(); check("dn_t2", duty, 98);
    pulse_tick(); check("dn_t3", duty, 97);
    @(negedge clk);
    check("dn_done", done, 1);
    @(negedge clk);

    // ---------------- async reset mid-fade ----------------
    do_start(8'd0, 8'd10, 1'b0, 8'd0);
    pulse_tick(); check("ar_t1", duty, 87);
    #2 rst = 1'b1;
    #1;
    check("ar_duty", duty, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_duty_after", duty, 0);

    // ---------------- breathe 0 <-> 40, step 20, hold 2 ----------------
    done_base = done_cnt;
    do_start(8'd40, 8'd20, 1'b1, 8'd2);
    pulse_tick(); check("br_t1", duty, 20);
    pulse_tick(); check("br_t2", duty, 40);
    pulse_tick(); check("br_h1", duty, 40);
    pulse_tick(); check("br_h2", duty, 40);
    pulse_tick(); check("br_t5", duty, 20);
    pulse_tick(); check("br_t6", duty, 0);
    pulse_tick(); check("br_h3", duty, 0);
    pulse_tick(); check("br_h4", duty, 0);
    check("br_busy", busy, 1);
    pulse_tick(); check("br_t9", duty, 20);
    pulse_tick(); check("br_t10", duty, 40);
    check("br_no_done", done_cnt - done_base, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("br_stop_busy", busy, 0);
    check("br_stop_duty", duty, 40);

    // ---------------- stop with tick and start on same cycle ----------------
    done_base = done_cnt;
    do_start(8'd200, 8'd20, 1'b0, 8'd0);
    pulse_tick(); check("sp_t1", duty, 60);
    repeat (3) @(negedge clk);
    stop = 1'b1; tick = 1'b1; start = 1'b1; target = 8'd0;
    @(negedge clk);
    stop = 1'b0; tick = 1'b0; start = 1'b0;
    check("sp_duty", duty, 60);
    check("sp_busy", busy, 0);
    @(negedge clk);
    check("sp_busy_later", busy, 0);
    check("sp_duty_later", duty, 60);
    check("sp_no_done", done_cnt - done_base, 0);

    // ---------------- saturation ----------------
    do_start(8'd250, 8'd200, 1'b0, 8'd0);
    pulse_tick(); check("sat_250", duty, 250);
    @(negedge clk);
    check("sat_250_done", done, 1);
    @(negedge clk);
    do_start(8'd255, 8'd200, 1'b0, 8'd0);
    pulse_tick(); check("sat_255", duty, 255);
    @(negedge clk);
    check("sat_255_done", done, 1);
    @(negedge clk);

    // start with target already equal to duty: no tick needed
    do_start(8'd255, 8'd5, 1'b0, 8'd0);
    check("eq_busy", busy, 1);
    check("eq_done0", done, 0);
    @(negedge clk);
    check("eq_busy_fall", busy, 0);
    check("eq_done", done, 1);
    check("eq_duty", duty, 255);
    @(negedge clk);

    // downward saturation: 255 -> 55 -> 0 (borrow must clamp)
    do_start(8'd0, 8'd200, 1'b0, 8'd0);
    pulse_tick(); check("dsat_t1", duty, 55);
    pulse_tick(); check("dsat_t2", duty, 0);
    @(negedge clk);
    check("dsat_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_led_fade_ctrl
